banked_memory_bus: RTL and testbench
====================================

BANKED_MEMORY_BUS -- requirements
Module: banked_memory_bus

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, CPU and bank data width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, CPU address width in bits.
REQ-003 SHALL have parameter BANK_BITS, default 2, number of top address bits used as bank select; NUM_BANKS = 2**BANK_BITS.
REQ-004 SHALL have parameter RO_MASK, default 4'b0010, one bit per bank; a set bit marks that bank read-only (ROM).
REQ-005 SHALL have parameter TIMEOUT, default 255, maximum WAIT cycles before abort; counter width is clog2(TIMEOUT+1).
REQ-006 SHALL have ports, clock and reset first:
- clk  input  1  single system clock, all logic on rising edge
- reset  input  1  asynchronous active-low reset
- address  input  ADDR_WIDTH  CPU address
- data_in  input  DATA_WIDTH  CPU write data
- data_out  output  DATA_WIDTH  registered read data
- bus_enable  input  1  transaction request
- write_enable  input  1  1 = write, 0 = read; sampled with bus_enable
- busy  output  1  transaction in progress
- done  output  1  one-cycle completion pulse
- bus_error  output  1  last transaction timed out
- bank_address  output  ADDR_WIDTH-BANK_BITS  latched offset within bank
- bank_data_in  output  DATA_WIDTH  latched write data to banks
- bank_data_out  input  NUM_BANKS*DATA_WIDTH  flattened bank read data, bank k at [k*DATA_WIDTH +: DATA_WIDTH]
- bank_chip_enable  output  NUM_BANKS  one-hot access strobe
- bank_write_enable  output  NUM_BANKS  one-hot write strobe
- bank_ready  input  NUM_BANKS  per-bank ready/acknowledge

Function
REQ-007 SHALL implement the FSM states IDLE, ACCESS, WAIT, DONE.
REQ-008 In IDLE, bus_enable=1 SHALL latch address, data_in, write_enable, and bank select address[ADDR_WIDTH-1 -: BANK_BITS]; clear bus_error; and enter ACCESS.
REQ-009 bus_enable SHALL be ignored in ACCESS, WAIT and DONE; requests are not queued.
REQ-010 In ACCESS and WAIT, bank_chip_enable[sel] SHALL be 1 and all other bits 0.
REQ-011 In ACCESS and WAIT, bank_write_enable[sel] SHALL be 1 only for a write to a bank whose RO_MASK bit is 0.
REQ-012 A write to a read-only bank SHALL complete normally with no write strobe and data_out unchanged.
REQ-013 ACCESS SHALL go to DONE if bank_ready[sel]=1, else to WAIT.
REQ-014 WAIT SHALL go to DONE on the first cycle bank_ready[sel]=1.
REQ-015 On entry to DONE after a read, data_out SHALL load bank_data_out slice sel; writes SHALL leave data_out unchanged.
REQ-016 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-017 Minimum latency SHALL be 2 cycles from the bus_enable sample edge to done=1.
REQ-018 busy SHALL be 0 only in IDLE; done SHALL be 1 only in DONE.
REQ-019 bank_address and bank_data_in SHALL hold stable from ACCESS through DONE.
REQ-020 bank_ready bits of non-selected banks SHALL be ignored.

Reset
REQ-021 Asserting reset low at any time, including mid-transaction, SHALL immediately force:
- state IDLE
- data_out 0, busy 0, done 0, bus_error 0
- all bank strobes 0
- bank_address 0, bank_data_in 0
- timeout counter 0
REQ-022 The first request SHALL be accepted on the first rising clk edge after reset deasserts.

Configuration
REQ-023 With BUS_TIMEOUT_EN defined:
- a counter SHALL clear in ACCESS and increment each WAIT cycle
- when it reaches TIMEOUT with bank_ready[sel]=0, the FSM SHALL enter DONE
- bus_error SHALL be set to 1 and held until the next accepted request
- data_out SHALL be loaded with all ones on a timed-out read
REQ-024 Without BUS_TIMEOUT_EN, WAIT SHALL persist indefinitely, bus_error SHALL be tied 0, and no counter logic SHALL exist.

Structure
REQ-025 Package memory_bus_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-026 Sub-module bank_decoder SHALL produce the one-hot bank select from the bank bits and implement the read-data mux; the FSM stays in banked_memory_bus.

Verification
REQ-027 Read bank 0 at 0x0005, bank_ready tied 1, bank0 data 0x1234 -> done on cycle 2, data_out=0x1234, bank_chip_enable=4'b0001 for 1 cycle.
REQ-028 Write 0xBEEF to 0xC010 (bank 3), ready after 3 WAIT cycles -> bank_write_enable=4'b1000 for 4 cycles, bank_address=0x0010, done on cycle 5.
REQ-029 Write 0xAAAA to 0x4001 (bank 1, read-only) -> bank_write_enable stays 0, done on cycle 2, data_out unchanged.
REQ-030 With BUS_TIMEOUT_EN and TIMEOUT=4, read bank 2 with bank_ready=0 -> done after 4 WAIT cycles, bus_error=1, data_out=0xFFFF; next request clears bus_error.
REQ-031 Assert reset during WAIT -> strobes, busy and done all 0 asynchronously; a later read completes normally.
REQ-032 Pulse bus_enable during WAIT with a different address -> ignored; only the original transaction completes.

Source files
------------

// File: rtl/memory_bus_pkg.sv
// rtl/memory_bus_pkg.sv - shared FSM state type and default parameters for banked_memory_bus
package memory_bus_pkg;

    localparam int         DEFAULT_DATA_WIDTH = 16;
    localparam int         DEFAULT_ADDR_WIDTH = 16;
    localparam int         DEFAULT_BANK_BITS  = 2;
    localparam int         DEFAULT_TIMEOUT    = 255;
    localparam logic [3:0] DEFAULT_RO_MASK    = 4'b0010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_DONE
    } bus_state_t;

endpackage

// File: rtl/bank_decoder.sv
// rtl/bank_decoder.sv - one-hot bank select and read-data mux for banked_memory_bus
module bank_decoder #(
    parameter int DATA_WIDTH = 16,
    parameter int BANK_BITS  = 2
) (
    input  logic [BANK_BITS-1:0]                   bank_sel,
    input  logic [(2**BANK_BITS)*DATA_WIDTH-1:0]   bank_data_out,
    output logic [(2**BANK_BITS)-1:0]              one_hot,
    output logic [DATA_WIDTH-1:0]                  rd_data
);

    always_comb begin
        one_hot           = '0;
        one_hot[bank_sel] = 1'b1;
        rd_data           = bank_data_out[bank_sel*DATA_WIDTH +: DATA_WIDTH];
    end

endmodule

// File: rtl/banked_memory_bus.sv
// rtl/banked_memory_bus.sv - CPU-to-banked-memory bridge FSM; optional timeout with BUS_TIMEOUT_EN
module banked_memory_bus
    import memory_bus_pkg::*;
#(
    parameter int                          DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int                          ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int                          BANK_BITS  = DEFAULT_BANK_BITS,
    parameter logic [(2**BANK_BITS)-1:0]   RO_MASK    = DEFAULT_RO_MASK,
    parameter int                          TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [ADDR_WIDTH-1:0]                 address,
    input  logic [DATA_WIDTH-1:0]                 data_in,
    output logic [DATA_WIDTH-1:0]                 data_out,
    input  logic                                  bus_enable,
    input  logic                                  write_enable,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  bus_error,
    output logic [ADDR_WIDTH-BANK_BITS-1:0]       bank_address,
    output logic [DATA_WIDTH-1:0]                 bank_data_in,
    input  logic [(2**BANK_BITS)*DATA_WIDTH-1:0]  bank_data_out,
    output logic [(2**BANK_BITS)-1:0]             bank_chip_enable,
    output logic [(2**BANK_BITS)-1:0]             bank_write_enable,
    input  logic [(2**BANK_BITS)-1:0]             bank_ready
);

    localparam int NUM_BANKS = 2**BANK_BITS;

    bus_state_t             state;
    logic [BANK_BITS-1:0]   sel_q;
    logic                   we_q;
    logic [BANK_BITS-1:0]   req_sel;
    logic [BANK_BITS-1:0]   dec_sel;
    logic [NUM_BANKS-1:0]   dec_hot;
    logic [DATA_WIDTH-1:0]  dec_rd;
    logic                   ready_sel;
    logic                   timed_out;

    assign req_sel   = address[ADDR_WIDTH-1 -: BANK_BITS];
    // While idle the decoder looks at the incoming request so the strobes can be registered on acceptance
    assign dec_sel   = (state == ST_IDLE) ? req_sel : sel_q;
    assign ready_sel = bank_ready[sel_q];

    bank_decoder #(
        .DATA_WIDTH (DATA_WIDTH),
        .BANK_BITS  (BANK_BITS)
    ) u_bank_decoder (
        .bank_sel      (dec_sel),
        .bank_data_out (bank_data_out),
        .one_hot       (dec_hot),
        .rd_data       (dec_rd)
    );

`ifdef BUS_TIMEOUT_EN
    localparam int                CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt;

    assign timed_out = (state == ST_WAIT) && !ready_sel && (wait_cnt == TO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt  <= '0;
            bus_error <= 1'b0;
        end else begin
            if (state == ST_IDLE && bus_enable)
                bus_error <= 1'b0;
            else if (timed_out)
                bus_error <= 1'b1;

            if (state == ST_ACCESS)
                wait_cnt <= '0;
            else if (state == ST_WAIT && !ready_sel)
                wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`else
    assign timed_out = 1'b0;
    assign bus_error = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= ST_IDLE;
            sel_q             <= '0;
            we_q              <= 1'b0;
            data_out          <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            bank_address      <= '0;
            bank_data_in      <= '0;
            bank_chip_enable  <= '0;
            bank_write_enable <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (bus_enable) begin
                        state             <= ST_ACCESS;
                        busy              <= 1'b1;
                        sel_q             <= req_sel;
                        we_q              <= write_enable;
                        bank_address      <= address[ADDR_WIDTH-BANK_BITS-1:0];
                        bank_data_in      <= data_in;
                        bank_chip_enable  <= dec_hot;
                        bank_write_enable <= (write_enable && !RO_MASK[req_sel]) ? dec_hot : '0;
                    end
                end
                ST_ACCESS, ST_WAIT: begin
                    if (ready_sel || timed_out) begin
                        state             <= ST_DONE;
                        done              <= 1'b1;
                        bank_chip_enable  <= '0;
                        bank_write_enable <= '0;
                        if (!we_q)
                            data_out <= ready_sel ? dec_rd : '1;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_banked_memory_bus.sv
// tb/tb_banked_memory_bus.sv - directed vector bench for banked_memory_bus
module tb_banked_memory_bus;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int NB = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [AW-1:0]   address;
    logic [DW-1:0]   data_in;
    logic [DW-1:0]   data_out;
    logic            bus_enable;
    logic            write_enable;
    logic            busy;
    logic            done;
    logic            bus_error;
    logic [AW-3:0]   bank_address;
    logic [DW-1:0]   bank_data_in;
    logic [NB*DW-1:0] bank_data_out;
    logic [NB-1:0]   bank_chip_enable;
    logic [NB-1:0]   bank_write_enable;
    logic [NB-1:0]   bank_ready;

    always #5 clk = ~clk;

    banked_memory_bus #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .BANK_BITS  (2),
        .RO_MASK    (4'b0010),
        .TIMEOUT    (4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .address           (address),
        .data_in           (data_in),
        .data_out          (data_out),
        .bus_enable        (bus_enable),
        .write_enable      (write_enable),
        .busy              (busy),
        .done              (done),
        .bus_error         (bus_error),
        .bank_address      (bank_address),
        .bank_data_in      (bank_data_in),
        .bank_data_out     (bank_data_out),
        .bank_chip_enable  (bank_chip_enable),
        .bank_write_enable (bank_write_enable),
        .bank_ready        (bank_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        we;
        int          wait_n;
        logic [3:0]  exp_ce;
        logic [3:0]  exp_we;
        logic [13:0] exp_baddr;
        logic [15:0] exp_dout;
    } vec_t;

    vec_t vecs[7];

    int          done_cyc, ce_cyc, we_cyc;
    logic [3:0]  ce_acc, we_acc;
    logic [13:0] ba_acc;

    task automatic run_txn(input logic [15:0] a, input logic [15:0] d, input logic w,
                           input int wait_n, input int max_c);
        logic [3:0] hot;
        logic [1:0] bsel;
        bsel = a[15:14];
        hot  = 4'b0001 << bsel;
        address      = a;
        data_in      = d;
        write_enable = w;
        bus_enable   = 1'b1;
        bank_ready   = (wait_n == 0) ? 4'b1111 : ~hot;
        tick;
        bus_enable = 1'b0;
        ce_acc   = bank_chip_enable;
        we_acc   = bank_write_enable;
        ba_acc   = bank_address;
        done_cyc = 0;
        ce_cyc   = 0;
        we_cyc   = 0;
        for (int c = 1; c <= max_c; c++) begin
            if (done) begin
                done_cyc = c;
                break;
            end
            bank_ready = (c >= 1 + wait_n) ? 4'b1111 : ~hot;
            if (bank_chip_enable != 4'b0000) ce_cyc++;
            if (bank_write_enable != 4'b0000) we_cyc++;
            tick;
        end
    endtask

    initial begin
        vecs[0] = '{16'h0005, 16'h0000, 1'b0, 0, 4'b0001, 4'b0000, 14'h0005, 16'h1234};
        vecs[1] = '{16'hC010, 16'hBEEF, 1'b1, 3, 4'b1000, 4'b1000, 14'h0010, 16'h1234};
        vecs[2] = '{16'h4001, 16'hAAAA, 1'b1, 0, 4'b0010, 4'b0000, 14'h0001, 16'h1234};
        vecs[3] = '{16'h4001, 16'h0000, 1'b0, 1, 4'b0010, 4'b0000, 14'h0001, 16'h5A5A};
        vecs[4] = '{16'h8FFF, 16'h0000, 1'b0, 2, 4'b0100, 4'b0000, 14'h0FFF, 16'h0F0F};
        vecs[5] = '{16'h3FFF, 16'h0123, 1'b1, 1, 4'b0001, 4'b0001, 14'h3FFF, 16'h0F0F};
        vecs[6] = '{16'hFFFF, 16'h0000, 1'b0, 0, 4'b1000, 4'b0000, 14'h3FFF, 16'hC3C3};

        reset         = 1'b0;
        address       = '0;
        data_in       = '0;
        bus_enable    = 1'b0;
        write_enable  = 1'b0;
        bank_ready    = 4'b0000;
        bank_data_out = {16'hC3C3, 16'h0F0F, 16'h5A5A, 16'h1234};

        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", bus_error, 0);
        check("rst_dout", data_out, 0);
        check("rst_ce", bank_chip_enable, 0);
        check("rst_baddr", bank_address, 0);
        reset = 1'b1;
        tick;

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].wait_n, 50);
            check($sformatf("v%0d_ce", i), ce_acc, vecs[i].exp_ce);
            check($sformatf("v%0d_we", i), we_acc, vecs[i].exp_we);
            check($sformatf("v%0d_baddr", i), ba_acc, vecs[i].exp_baddr);
            check($sformatf("v%0d_done_cyc", i), done_cyc, vecs[i].wait_n + 2);
            check($sformatf("v%0d_ce_cycles", i), ce_cyc, vecs[i].wait_n + 1);
            check($sformatf("v%0d_we_cycles", i), we_cyc, (vecs[i].exp_we != 0) ? vecs[i].wait_n + 1 : 0);
            check($sformatf("v%0d_dout", i), data_out, vecs[i].exp_dout);
            check($sformatf("v%0d_done_busy", i), busy, 1);
            if (vecs[i].we && vecs[i].exp_we != 0)
                check($sformatf("v%0d_bdata", i), bank_data_in, vecs[i].wdata);
            tick;
            check($sformatf("v%0d_idle_done", i), done, 0);
            check($sformatf("v%0d_idle_busy", i), busy, 0);
        end

        // request while waiting must not disturb the transaction in flight
        address      = 16'h8002;
        write_enable = 1'b0;
        bus_enable   = 1'b1;
        bank_ready   = 4'b1011;
        tick;
        bus_enable = 1'b0;
        tick;
        address      = 16'h0003;
        write_enable = 1'b1;
        data_in      = 16'hDEAD;
        bus_enable   = 1'b1;
        tick;
        bus_enable = 1'b0;
        check("ign_ce", bank_chip_enable, 4'b0100);
        check("ign_we", bank_write_enable, 4'b0000);
        check("ign_baddr", bank_address, 14'h0002);
        bank_ready = 4'b1111;
        tick;
        check("ign_done", done, 1);
        check("ign_dout", data_out, 16'h0F0F);
        tick;
        tick;
        check("ign_no_queue_busy", busy, 0);
        check("ign_no_queue_ce", bank_chip_enable, 4'b0000);

`ifdef BUS_TIMEOUT_EN
        run_txn(16'h8004, 16'h0000, 1'b0, 1000, 50);
        check("to_done_cyc", done_cyc, 6);
        check("to_err", bus_error, 1);
        check("to_dout", data_out, 16'hFFFF);
        tick;
        tick;
        check("to_err_held", bus_error, 1);
        run_txn(16'h0000, 16'h0000, 1'b0, 0, 50);
        check("to_err_cleared", bus_error, 0);
        check("to_next_dout", data_out, 16'h1234);
        tick;
`else
        address      = 16'h8004;
        write_enable = 1'b0;
        bus_enable   = 1'b1;
        bank_ready   = 4'b1011;
        tick;
        bus_enable = 1'b0;
        for (int c = 0; c < 20; c++) tick;
        check("nto_busy", busy, 1);
        check("nto_done", done, 0);
        check("nto_err", bus_error, 0);
        check("nto_ce", bank_chip_enable, 4'b0100);
        reset = 1'b0;
        #1;
        reset = 1'b1;
        tick;
`endif

        // asynchronous reset in the middle of a WAIT
        address      = 16'hC000;
        write_enable = 1'b1;
        data_in      = 16'h5555;
        bus_enable   = 1'b1;
        bank_ready   = 4'b0111;
        tick;
        bus_enable = 1'b0;
        tick;
        tick;
        check("ar_pre_we", bank_write_enable, 4'b1000);
        #3;
        reset = 1'b0;
        #1;
        check("ar_ce", bank_chip_enable, 0);
        check("ar_we", bank_write_enable, 0);
        check("ar_busy", busy, 0);
        check("ar_done", done, 0);
        check("ar_dout", data_out, 0);
        check("ar_baddr", bank_address, 0);
        check("ar_bdata", bank_data_in, 0);
        #2;
        reset = 1'b1;
        run_txn(16'hC000, 16'h0000, 1'b0, 0, 50);
        check("ar_next_ce", ce_acc, 4'b1000);
        check("ar_next_done_cyc", done_cyc, 2);
        check("ar_next_dout", data_out, 16'hC3C3);
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
